imem_loader: RTL and testbench
==============================

# imem_loader

Program loader that sits directly upstream of the processor's instruction memory. It accepts a framed byte stream and assembles little-endian 32-bit instruction words, writing them into consecutive IMEM word addresses. It verifies an XOR checksum and only then releases the core through `core_run`; the core is held idle while `core_run` is 0.

## Interface

Parameters:
- ADDR_W, 8, IMEM word-address width; capacity 2^ADDR_W words.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low; 0 = reset asserted.
- start  in  1  single-cycle request to begin a load; sampled in IDLE, DONE and ERROR only.
- in_valid  in  1  byte-stream data valid.
- in_data  in  8  byte-stream payload.
- in_ready  out  1  loader can accept a byte this cycle.
- imem_wr_en  out  1  one-cycle IMEM write strobe.
- imem_wr_addr  out  ADDR_W  IMEM word address.
- imem_wr_data  out  32  assembled instruction word.
- core_run  out  1  program loaded and checksum good; core released.
- busy  out  1  load in progress, i.e. the state is one of HDR0, HDR1, DATA, CSUM.
- error  out  1  load aborted.
- error_code  out  2  01 = bad length, 10 = checksum mismatch, 00 = none.
- words_loaded  out  ADDR_W+1  count of words written in the current load.

## Operation

Frame format, in byte order:
- LEN_LO, LEN_HI: 16-bit word count N, little-endian.
- N×4 data bytes: each word is sent LSB first.
- CSUM: XOR of all data bytes only.

State machine:
- IDLE: `start` → HDR0. Clears `words_loaded`, `error`, `error_code`, the checksum accumulator and the byte counter.
- HDR0: accept a byte → latch LEN_LO, go to HDR1.
- HDR1: accept a byte → latch LEN_HI.
  - If N == 0 or N > 2^ADDR_W → ERROR with code 01.
  - Otherwise → DATA.
- DATA: each accepted byte shifts into the word register at byte lane `byte_cnt` (0..3) and XORs into the accumulator.
  - On the lane-3 byte, the write is issued (see Timing) and `byte_cnt` wraps to 0.
  - After the N-th word is written → CSUM.
- CSUM: accept a byte.
  - If it equals the accumulator → DONE.
  - Otherwise → ERROR with code 10.
- DONE: `core_run` = 1. `start` → HDR0, and `core_run` drops on the same edge.
- ERROR: `error` = 1, `core_run` = 0. `start` → HDR0 with error fields cleared.

Handshake and boundary rules:
- A byte transfers only on a rising edge where `in_valid` and `in_ready` are both 1.
- `in_ready` = 1 only in HDR0, HDR1, DATA and CSUM.
- `in_data` is ignored when no transfer occurs. Idle cycles between bytes are legal at any point.
- `start` while `busy` is ignored.
- Bytes presented in IDLE, DONE or ERROR are not consumed, because `in_ready` = 0.
- N == 2^ADDR_W is legal. The last word goes to address 2^ADDR_W−1; the address never wraps within a load.
- Reset asserted mid-load:
  - Every output goes to its reset value immediately and the state goes to IDLE.
  - Words already written stay in IMEM; no clearing is performed.
  - The next `start` begins a fresh frame.

## Timing

Reset values (asynchronous) apply while reset is 0: state IDLE, and `in_ready`, `imem_wr_en`, `imem_wr_addr`, `imem_wr_data`, `core_run`, `busy`, `error`, `error_code` and `words_loaded` all 0.

Write path:
- `imem_wr_en`, `imem_wr_addr` and `imem_wr_data` are registered.
- The strobe is high for exactly the one cycle after the edge that accepted a word's lane-3 byte.
- `imem_wr_addr` equals the word index, starting at 0.
- `words_loaded` increments on that same edge.

State transitions:
- HDR1→ERROR takes effect on the edge that accepts LEN_HI; `in_ready` is 0 in the next cycle.
- CSUM→DONE/ERROR: `core_run` or `error` asserts in the cycle after the CSUM byte is accepted.

Throughput and latency:
- Sustained throughput is 1 byte/clk and the loader never deasserts `in_ready` mid-frame.
- Minimum full-load latency is 2 + 4N + 1 accepted bytes, plus 1 cycle for `core_run`.

## Test plan

1. Reset, start, stream 00 01 | 13 00 00 00 | 93 00 10 00 | CSUM.
   - Wait: LEN_HI = 01 would give N = 256; ADDR_W = 8 allows that, but the intended frame is N = 2. Use LEN_LO, LEN_HI = 02 00 instead.
   - Required: writes addr 0 = 0x00000013 and addr 1 = 0x00100093, each strobe 1 cycle wide.
   - CSUM = 0x13^0x93^0x10 = 0x90 → `core_run` = 1, `words_loaded` = 2.
2. Same frame with CSUM = 0x91 → both writes still occur, `error` = 1, `error_code` = 10, `core_run` = 0, `in_ready` = 0.
3. LEN = 00 00 → ERROR with code 01 after the second byte, and no IMEM writes. LEN = 01 01 (N = 257) → ERROR with code 01.
4. N = 256 frame with random `in_valid` gaps (≥30% idle) → 256 writes at addresses 0..255 in order, data matching, `core_run` = 1. A `start` pulse mid-load has no effect.
5. Reset asserted after 6 data bytes → all outputs 0 immediately. Restart with a valid N = 1 frame → single write to addr 0, `core_run` = 1.
6. Start from DONE → `core_run` drops on the start edge; the reload completes normally with the new data.

Source files
------------

// File: rtl/imem_loader.sv
// Framed byte-stream program loader: assembles little-endian words into IMEM,
// verifies an XOR checksum over the data bytes, then releases the core.
module imem_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              imem_wr_en,
  output logic [ADDR_W-1:0] imem_wr_addr,
  output logic [31:0]       imem_wr_data,
  output logic              core_run,
  output logic              busy,
  output logic              error,
  output logic [1:0]        error_code,
  output logic [ADDR_W:0]   words_loaded
);

  typedef enum logic [2:0] {
    S_IDLE, S_HDR0, S_HDR1, S_DATA, S_CSUM, S_DONE, S_ERROR
  } state_t;

  localparam logic [16:0]     CAPACITY = 17'(1) << ADDR_W;
  localparam logic [ADDR_W:0] ONE_WORD = (ADDR_W + 1)'(1);

  state_t              r_state;
  state_t              w_next;
  logic [7:0]          r_len_lo;
  logic [ADDR_W:0]     r_len;
  logic [7:0]          r_acc;
  logic [1:0]          r_byte_cnt;
  logic [23:0]         r_word;
  logic                r_wr_en;
  logic [ADDR_W-1:0]   r_wr_addr;
  logic [31:0]         r_wr_data;
  logic [ADDR_W:0]     r_words;
  logic [1:0]          r_err_code;

  logic                w_active;
  logic                w_xfer;
  logic                w_start;
  logic [15:0]         w_len_full;
  logic                w_len_bad;
  logic                w_last_word;
  logic                w_csum_ok;

  assign w_active    = (r_state == S_HDR0) || (r_state == S_HDR1) ||
                       (r_state == S_DATA) || (r_state == S_CSUM);
  assign w_xfer      = in_valid && w_active;
  assign w_start     = start && !w_active;
  assign w_len_full  = {in_data, r_len_lo};
  assign w_len_bad   = (w_len_full == 16'd0) || ({1'b0, w_len_full} > CAPACITY);
  assign w_last_word = (r_byte_cnt == 2'd3) && ((r_words + ONE_WORD) == r_len);
  assign w_csum_ok   = (in_data == r_acc);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE, S_ERROR: if (w_start) w_next = S_HDR0;
      S_HDR0:  if (w_xfer) w_next = S_HDR1;
      S_HDR1:  if (w_xfer) w_next = w_len_bad ? S_ERROR : S_DATA;
      S_DATA:  if (w_xfer && w_last_word) w_next = S_CSUM;
      S_CSUM:  if (w_xfer) w_next = w_csum_ok ? S_DONE : S_ERROR;
      default: w_next = S_IDLE;
    endcase
  end

  // Lanes 0..2 are held in r_word; the lane-3 byte completes the word and
  // launches the registered write directly, so no extra assembly cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_len_lo   <= '0;
      r_len      <= '0;
      r_acc      <= '0;
      r_byte_cnt <= '0;
      r_word     <= '0;
      r_wr_en    <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
      r_words    <= '0;
      r_err_code <= '0;
    end else begin
      r_wr_en <= 1'b0;
      if (w_start) begin
        r_words    <= '0;
        r_err_code <= '0;
        r_acc      <= '0;
        r_byte_cnt <= '0;
      end
      if (w_xfer) begin
        case (r_state)
          S_HDR0: r_len_lo <= in_data;
          S_HDR1: begin
            r_len <= w_len_full[ADDR_W:0];
            if (w_len_bad) r_err_code <= 2'b01;
          end
          S_DATA: begin
            r_acc      <= r_acc ^ in_data;
            r_byte_cnt <= r_byte_cnt + 2'd1;
            if (r_byte_cnt == 2'd3) begin
              r_wr_en   <= 1'b1;
              r_wr_addr <= r_words[ADDR_W-1:0];
              r_wr_data <= {in_data, r_word};
              r_words   <= r_words + ONE_WORD;
            end else begin
              r_word[{r_byte_cnt, 3'b000} +: 8] <= in_data;
            end
          end
          S_CSUM: if (!w_csum_ok) r_err_code <= 2'b10;
          default: ;
        endcase
      end
    end
  end

  assign in_ready     = w_active;
  assign busy         = w_active;
  assign core_run     = (r_state == S_DONE);
  assign error        = (r_state == S_ERROR);
  assign error_code   = r_err_code;
  assign imem_wr_en   = r_wr_en;
  assign imem_wr_addr = r_wr_addr;
  assign imem_wr_data = r_wr_data;
  assign words_loaded = r_words;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected IMEM writes are queued as frames
// are driven and popped by a write monitor; each scenario task checks status.
module tb_imem_loader;

  localparam int ADDR_W = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              imem_wr_en;
  logic [ADDR_W-1:0] imem_wr_addr;
  logic [31:0]       imem_wr_data;
  logic              core_run;
  logic              busy;
  logic              error;
  logic [1:0]        error_code;
  logic [ADDR_W:0]   words_loaded;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  int          errors = 0;
  int          checks = 0;
  wr_t         exp_q[$];
  wr_t         mon_e;
  logic        prev_wr_en = 1'b0;
  logic [31:0] prog [0:255];

  imem_loader #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .imem_wr_en(imem_wr_en), .imem_wr_addr(imem_wr_addr),
    .imem_wr_data(imem_wr_data), .core_run(core_run), .busy(busy), .error(error),
    .error_code(error_code), .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  // Write monitor: every strobe must match the oldest queued write and be one cycle wide.
  always @(negedge clk) begin
    if (imem_wr_en === 1'b1) begin
      checks++;
      if (prev_wr_en === 1'b1) begin
        errors++;
        $display("[TB] FAIL strobe_width: imem_wr_en high two cycles, addr=%0d", imem_wr_addr);
      end
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_write: addr=%0d data=%08h, none expected", imem_wr_addr, imem_wr_data);
      end else begin
        mon_e = exp_q.pop_front();
        if (imem_wr_addr !== mon_e.addr || imem_wr_data !== mon_e.data) begin
          errors++;
          $display("[TB] FAIL write: got addr=%0d data=%08h, expected addr=%0d data=%08h",
                   imem_wr_addr, imem_wr_data, mon_e.addr, mon_e.data);
        end
      end
    end
    prev_wr_en = imem_wr_en;
  end

  task automatic idle_cycles(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      in_data = 8'($urandom);
      @(posedge clk); #1;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap_pct);
    bit ok;
    if (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) idle_cycles($urandom_range(1, 3));
    in_valid = 1'b1;
    in_data  = b;
    ok = 1'b0;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (in_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("[TB] FAIL handshake_timeout: in_ready stayed %b, required 1", in_ready);
    end
  endtask

  task automatic load_frame(input int n, input bit bad_csum, input int gap_pct, input bit mid_start);
    logic [7:0]  cs;
    logic [15:0] len;
    logic [31:0] w;
    wr_t         e;
    cs  = 8'h00;
    len = 16'(n);
    send_byte(len[7:0], gap_pct);
    send_byte(len[15:8], gap_pct);
    for (int i = 0; i < n; i++) begin
      w = prog[i];
      e.addr = i[ADDR_W-1:0];
      e.data = w;
      exp_q.push_back(e);
      for (int b = 0; b < 4; b++) begin
        cs ^= w[8*b +: 8];
        send_byte(w[8*b +: 8], gap_pct);
      end
      if (mid_start && i == 100) pulse_start();
    end
    send_byte(bad_csum ? (cs ^ 8'h01) : cs, gap_pct);
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    #23;
    checks++;
    if ({in_ready, imem_wr_en, core_run, busy, error} !== 5'b0) begin
      errors++;
      $display("[TB] FAIL reset_flags: rdy/wr/run/busy/err=%b, required 00000",
               {in_ready, imem_wr_en, core_run, busy, error});
    end
    checks++;
    if ({imem_wr_addr, imem_wr_data, error_code, words_loaded} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_values: addr=%0d data=%08h code=%b words=%0d, required all 0",
               imem_wr_addr, imem_wr_data, error_code, words_loaded);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    idle_cycles(2);
  endtask

  task automatic test_basic();
    prog[0] = 32'h0000_0013;
    prog[1] = 32'h0010_0093;
    pulse_start();
    load_frame(2, 1'b0, 0, 1'b0);
    @(negedge clk);
    checks++;
    if (core_run !== 1'b1 || error !== 1'b0) begin
      errors++;
      $display("[TB] FAIL basic_run: core_run=%b error=%b, required 1/0", core_run, error);
    end
    checks++;
    if (words_loaded !== 9'd2) begin
      errors++;
      $display("[TB] FAIL basic_words: words_loaded=%0d, required 2", words_loaded);
    end
    checks++;
    if (in_ready !== 1'b0 || exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL basic_done: in_ready=%b pending=%0d, required 0/0", in_ready, exp_q.size());
    end
  endtask

  task automatic test_bad_csum();
    pulse_start();
    load_frame(2, 1'b1, 0, 1'b0);
    @(negedge clk);
    checks++;
    if (error !== 1'b1 || error_code !== 2'b10 || core_run !== 1'b0) begin
      errors++;
      $display("[TB] FAIL csum_error: error=%b code=%b core_run=%b, required 1/10/0",
               error, error_code, core_run);
    end
    checks++;
    if (in_ready !== 1'b0 || words_loaded !== 9'd2 || exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL csum_state: in_ready=%b words=%0d pending=%0d, required 0/2/0",
               in_ready, words_loaded, exp_q.size());
    end
  endtask

  task automatic test_bad_len();
    pulse_start();
    @(negedge clk);
    checks++;
    if (error !== 1'b0 || error_code !== 2'b00 || busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL restart_clear: error=%b code=%b busy=%b, required 0/00/1",
               error, error_code, busy);
    end
    @(posedge clk); #1;
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    @(negedge clk);
    checks++;
    if (error !== 1'b1 || error_code !== 2'b01 || in_ready !== 1'b0 || words_loaded !== 9'd0) begin
      errors++;
      $display("[TB] FAIL len_zero: error=%b code=%b in_ready=%b words=%0d, required 1/01/0/0",
               error, error_code, in_ready, words_loaded);
    end
    @(posedge clk); #1;
    pulse_start();
    send_byte(8'h01, 0);
    send_byte(8'h01, 0);
    @(negedge clk);
    checks++;
    if (error !== 1'b1 || error_code !== 2'b01 || in_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL len_257: error=%b code=%b in_ready=%b, required 1/01/0",
               error, error_code, in_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_full_load();
    for (int i = 0; i < 256; i++) prog[i] = $urandom;
    pulse_start();
    load_frame(256, 1'b0, 50, 1'b1);
    @(negedge clk);
    checks++;
    if (core_run !== 1'b1 || error !== 1'b0) begin
      errors++;
      $display("[TB] FAIL full_run: core_run=%b error=%b, required 1/0", core_run, error);
    end
    checks++;
    if (words_loaded !== 9'd256 || exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL full_words: words=%0d pending=%0d, required 256/0", words_loaded, exp_q.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_load();
    wr_t e;
    prog[0] = $urandom;
    prog[1] = $urandom;
    pulse_start();
    send_byte(8'h02, 0);
    send_byte(8'h00, 0);
    e.addr = '0;
    e.data = prog[0];
    exp_q.push_back(e);
    for (int b = 0; b < 4; b++) send_byte(prog[0][8*b +: 8], 0);
    send_byte(prog[1][7:0], 0);
    send_byte(prog[1][15:8], 0);
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if ({in_ready, imem_wr_en, core_run, busy, error} !== 5'b0 ||
        {imem_wr_addr, imem_wr_data, error_code, words_loaded} !== '0) begin
      errors++;
      $display("[TB] FAIL midload_reset: rdy=%b wr=%b run=%b busy=%b err=%b addr=%0d data=%08h code=%b words=%0d, required all 0",
               in_ready, imem_wr_en, core_run, busy, error, imem_wr_addr, imem_wr_data, error_code, words_loaded);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    idle_cycles(2);
    prog[0] = $urandom;
    pulse_start();
    load_frame(1, 1'b0, 0, 1'b0);
    @(negedge clk);
    checks++;
    if (core_run !== 1'b1 || words_loaded !== 9'd1 || exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL after_reset_load: core_run=%b words=%0d pending=%0d, required 1/1/0",
               core_run, words_loaded, exp_q.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    prog[0] = $urandom;
    prog[1] = $urandom;
    pulse_start();
    @(negedge clk);
    checks++;
    if (core_run !== 1'b0 || busy !== 1'b1 || words_loaded !== 9'd0) begin
      errors++;
      $display("[TB] FAIL reload_start: core_run=%b busy=%b words=%0d, required 0/1/0",
               core_run, busy, words_loaded);
    end
    @(posedge clk); #1;
    load_frame(2, 1'b0, 20, 1'b0);
    @(negedge clk);
    checks++;
    if (core_run !== 1'b1 || words_loaded !== 9'd2 || exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL reload_done: core_run=%b words=%0d pending=%0d, required 1/2/0",
               core_run, words_loaded, exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bad_csum();
    test_bad_len();
    test_full_load();
    test_reset_mid_load();
    test_back_to_back();
    idle_cycles(3);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
